pht_update_ctrl: RTL and testbench

Controller for the gshare pattern history table (PHT) of the PC stage. It owns the single read/write port of the 2-bit counter table and arbitrates each cycle between three users: the PC-stage prediction lookup, the read-modify-write of counter updates queued from ID, and the post-reset/flush initialisation sweep. It also maintains the global history register (GHR) and forms the gshare index.

---
 rtl/pht_update_ctrl_pkg.sv | 20 ++
 rtl/pht_update_ctrl_if.sv | 35 +++
 rtl/pht_update_ctrl_upd_fifo.sv | 46 ++++
 rtl/pht_update_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pht_update_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pht_update_ctrl_pkg.sv
// rtl/pht_update_ctrl_pkg.sv - shared gshare constants, FSM encoding and counter helper
package pht_update_ctrl_pkg;

  localparam int GHR_WIDTH_DEF = 5;
  localparam int PHT_SIZE = 1 << GHR_WIDTH_DEF;
  localparam logic [1:0] CTR_INIT = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WR   = 2'd2
  } pht_state_e;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/pht_update_ctrl_if.sv
// rtl/pht_update_ctrl_if.sv - lookup, update, table-port and status signals of the PHT controller
interface pht_update_ctrl_if #(parameter int GHR_WIDTH = 5);

  logic                 clear;
  logic                 lookup_valid;
  logic [31:0]          lookup_pc;
  logic                 lookup_ready;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [GHR_WIDTH-1:0] pred_index;
  logic                 upd_valid;
  logic                 upd_taken;
  logic [GHR_WIDTH-1:0] upd_index;
  logic                 upd_ready;
  logic                 pht_en;
  logic                 pht_we;
  logic [GHR_WIDTH-1:0] pht_addr;
  logic [1:0]           pht_wdata;
  logic [1:0]           pht_rdata;
  logic                 busy;

  // master: fetch/decode side plus the table macro; slave: the controller.
  modport master (
    output clear, lookup_valid, lookup_pc, upd_valid, upd_taken, upd_index, pht_rdata,
    input  lookup_ready, pred_valid, pred_taken, pred_index, upd_ready,
           pht_en, pht_we, pht_addr, pht_wdata, busy
  );

  modport slave (
    input  clear, lookup_valid, lookup_pc, upd_valid, upd_taken, upd_index, pht_rdata,
    output lookup_ready, pred_valid, pred_taken, pred_index, upd_ready,
           pht_en, pht_we, pht_addr, pht_wdata, busy
  );

endinterface

// File: rtl/pht_update_ctrl_upd_fifo.sv
// rtl/pht_update_ctrl_upd_fifo.sv - update queue of {index, taken} entries with synchronous flush
module pht_update_ctrl_upd_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit separates full from empty when the low bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pht_update_ctrl.sv
// rtl/pht_update_ctrl.sv - gshare PHT port arbiter, GHR and init sweep; PHT_PERF_EN adds perf counters
module pht_update_ctrl
  import pht_update_ctrl_pkg::*;
#(
  parameter int GHR_WIDTH = GHR_WIDTH_DEF,
  parameter int UPD_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef PHT_PERF_EN
  pht_update_ctrl_if.slave bus,
  output logic [31:0] perf_lookup_cnt,
  output logic [31:0] perf_update_cnt,
  output logic [31:0] perf_stall_cnt
`else
  pht_update_ctrl_if.slave bus
`endif
);

  localparam logic [GHR_WIDTH-1:0] IDX_ONE = {{(GHR_WIDTH-1){1'b0}}, 1'b1};

  pht_state_e           state, state_nxt;
  logic [GHR_WIDTH-1:0] sweep_cnt;
  logic [GHR_WIDTH-1:0] ghr;
  logic [GHR_WIDTH-1:0] lookup_idx;
  logic [GHR_WIDTH-1:0] hold_index;
  logic                 hold_taken;
  logic                 pred_valid_q;
  logic                 pred_init;
  logic [GHR_WIDTH-1:0] pred_index_q;
  logic                 fifo_full, fifo_empty;
  logic [GHR_WIDTH:0]   fifo_head;
  logic                 rd_grant;
  logic                 upd_ready_int;
  logic                 upd_push;
  logic                 lookup_ready_int;
  logic                 lookup_fire;
  logic                 pht_en_c, pht_we_c;
  logic [GHR_WIDTH-1:0] pht_addr_c;
  logic [1:0]           pht_wdata_c;
  logic                 unused_pc;

  assign unused_pc  = ^{bus.lookup_pc[31:GHR_WIDTH+2], bus.lookup_pc[1:0]};
  assign lookup_idx = bus.lookup_pc[GHR_WIDTH+1:2] ^ ghr;

  assign upd_ready_int = !fifo_full && (state != ST_INIT);
  assign upd_push      = bus.upd_valid && upd_ready_int && !bus.clear;

  // Updates yield to lookups unless the queue would otherwise back up ID.
  assign rd_grant = (state == ST_IDLE) && !fifo_empty && (!bus.lookup_valid || fifo_full);

  assign lookup_ready_int = rst && ((state == ST_INIT) || ((state == ST_IDLE) && !rd_grant));
  assign lookup_fire      = bus.lookup_valid && lookup_ready_int;

  pht_update_ctrl_upd_fifo #(
    .WIDTH (GHR_WIDTH + 1),
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.clear),
    .push      (upd_push),
    .push_data ({bus.upd_index, bus.upd_taken}),
    .pop       (rd_grant),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt   = state;
    pht_en_c    = 1'b0;
    pht_we_c    = 1'b0;
    pht_addr_c  = '0;
    pht_wdata_c = '0;
    case (state)
      ST_INIT: begin
        pht_en_c    = 1'b1;
        pht_we_c    = 1'b1;
        pht_addr_c  = sweep_cnt;
        pht_wdata_c = CTR_INIT;
        if (sweep_cnt == '1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (rd_grant) begin
          pht_en_c   = 1'b1;
          pht_addr_c = fifo_head[GHR_WIDTH:1];
          state_nxt  = ST_WR;
        end else if (bus.lookup_valid) begin
          pht_en_c   = 1'b1;
          pht_addr_c = lookup_idx;
        end
      end
      ST_WR: begin
        pht_en_c    = 1'b1;
        pht_we_c    = 1'b1;
        pht_addr_c  = hold_index;
        pht_wdata_c = ctr_next(bus.pht_rdata, hold_taken);
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
    if (bus.clear) state_nxt = ST_INIT;
    if (!rst) begin
      pht_en_c = 1'b0;
      pht_we_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_INIT;
      sweep_cnt    <= '0;
      ghr          <= '0;
      hold_index   <= '0;
      hold_taken   <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_init    <= 1'b0;
      pred_index_q <= '0;
    end else begin
      state        <= state_nxt;
      pred_valid_q <= lookup_fire;
      if (lookup_fire) begin
        pred_index_q <= lookup_idx;
        pred_init    <= (state == ST_INIT);
      end
      if (rd_grant) begin
        hold_index <= fifo_head[GHR_WIDTH:1];
        hold_taken <= fifo_head[0];
      end
      if (bus.clear) begin
        sweep_cnt <= '0;
        ghr       <= '0;
      end else begin
        if (state == ST_INIT) sweep_cnt <= sweep_cnt + IDX_ONE;
        if (upd_push) ghr <= {ghr[GHR_WIDTH-2:0], bus.upd_taken};
      end
    end
  end

  assign bus.lookup_ready = lookup_ready_int;
  assign bus.upd_ready    = upd_ready_int;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_taken   = pred_valid_q && (pred_init || bus.pht_rdata[1]);
  assign bus.pred_index   = pred_index_q;
  assign bus.pht_en       = pht_en_c;
  assign bus.pht_we       = pht_we_c;
  assign bus.pht_addr     = pht_addr_c;
  assign bus.pht_wdata    = pht_wdata_c;
  assign bus.busy         = (state == ST_INIT);

`ifdef PHT_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lookup_cnt <= '0;
      perf_update_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else if (bus.clear) begin
      perf_lookup_cnt <= '0;
      perf_update_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (lookup_fire) perf_lookup_cnt <= perf_lookup_cnt + 32'd1;
      if (state == ST_WR) perf_update_cnt <= perf_update_cnt + 32'd1;
      if (bus.lookup_valid && !lookup_ready_int) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pht_update_ctrl.sv
// tb/tb_pht_update_ctrl.sv - directed self-checking bench for pht_update_ctrl with a table model
module tb_pht_update_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [1:0] mem [32];
  logic [1:0] rdata_q = 2'b00;

  pht_update_ctrl_if #(.GHR_WIDTH(5)) bus ();

`ifdef PHT_PERF_EN
  logic [31:0] perf_lookup_cnt, perf_update_cnt, perf_stall_cnt;
  pht_update_ctrl #(.GHR_WIDTH(5), .UPD_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_lookup_cnt(perf_lookup_cnt), .perf_update_cnt(perf_update_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );
`else
  pht_update_ctrl #(.GHR_WIDTH(5), .UPD_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  // Single-port table with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.pht_en) begin
      if (bus.pht_we) mem[bus.pht_addr] <= bus.pht_wdata;
      else            rdata_q <= mem[bus.pht_addr];
    end
  end
  assign bus.pht_rdata = rdata_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    bus.clear = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_pc = 32'h40;
    bus.upd_valid = 1'b0;
    bus.upd_taken = 1'b0;
    bus.upd_index = '0;
    #12;
    vectors++;
    if ({bus.busy, bus.pht_en, bus.pht_we, bus.lookup_ready, bus.upd_ready} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 10000", {bus.busy, bus.pht_en, bus.pht_we, bus.lookup_ready, bus.upd_ready});
    end
    vectors++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index} !== 7'h00) begin
      miscompares++;
      $display("FAIL reset_pred: got %h expected 00", {bus.pred_valid, bus.pred_taken, bus.pred_index});
    end
    tick();
    rst = 1'b1;
    bus.lookup_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      logic [4:0] ka;
      ka = k[4:0];
      settle();
      vectors++;
      if ({bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata, bus.busy, bus.pred_valid} !== {1'b1, 1'b1, ka, 2'b10, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL sweep_cycle%0d: got %b expected %b", k,
                 {bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata, bus.busy, bus.pred_valid},
                 {1'b1, 1'b1, ka, 2'b10, 1'b1, 1'b0});
      end
      tick();
    end
    settle();
    vectors++;
    if ({bus.busy, bus.pht_en, bus.upd_ready, bus.pred_valid} !== 4'b0010) begin
      miscompares++;
      $display("FAIL sweep_done: got %b expected 0010", {bus.busy, bus.pht_en, bus.upd_ready, bus.pred_valid});
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== 2'b10) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL sweep_contents: got %0d wrong entries expected 0", bad);
    end
  endtask

  task automatic test_init_lookup();
    int n;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_pc = 32'h40;
    settle();
    vectors++;
    if ({bus.busy, bus.lookup_ready, bus.pht_addr} !== {1'b1, 1'b1, 5'h00}) begin
      miscompares++;
      $display("FAIL init_lookup_accept: got %b expected 1100000", {bus.busy, bus.lookup_ready, bus.pht_addr});
    end
    tick();
    bus.lookup_valid = 1'b0;
    settle();
    vectors++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index} !== {1'b1, 1'b1, 5'h10}) begin
      miscompares++;
      $display("FAIL init_lookup_pred: got %h expected %h", {bus.pred_valid, bus.pred_taken, bus.pred_index}, {1'b1, 1'b1, 5'h10});
    end
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      settle();
      n++;
    end
    vectors++;
    if (n != 31) begin
      miscompares++;
      $display("FAIL init_busy_len: got %0d expected 31", n);
    end
  endtask

  task automatic upd_rmw(input logic [4:0] idx, input logic taken, input logic [1:0] expw);
    bus.upd_valid = 1'b1;
    bus.upd_taken = taken;
    bus.upd_index = idx;
    tick();
    bus.upd_valid = 1'b0;
    settle();
    vectors++;
    if ({bus.pht_en, bus.pht_we, bus.pht_addr} !== {1'b1, 1'b0, idx}) begin
      miscompares++;
      $display("FAIL rmw_read: got %b expected %b", {bus.pht_en, bus.pht_we, bus.pht_addr}, {1'b1, 1'b0, idx});
    end
    tick();
    settle();
    vectors++;
    if ({bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== {1'b1, 1'b1, idx, expw}) begin
      miscompares++;
      $display("FAIL rmw_write: got %b expected %b", {bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata}, {1'b1, 1'b1, idx, expw});
    end
    tick();
    settle();
  endtask

  task automatic test_counter_sat();
    upd_rmw(5'd3, 1'b1, 2'b11);
    upd_rmw(5'd3, 1'b1, 2'b11);
    upd_rmw(5'd3, 1'b1, 2'b11);
    upd_rmw(5'd3, 1'b0, 2'b10);
    upd_rmw(5'd3, 1'b0, 2'b01);
    upd_rmw(5'd3, 1'b0, 2'b00);
  endtask

  // ghr is now 5'b11000: pc 0x6C maps to index 3, pc 0x70 to index 4.
  task automatic test_back_to_back();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc = 32'h6C;
    #1;
    vectors++;
    if ({bus.lookup_ready, bus.pht_en, bus.pht_we, bus.pht_addr} !== {1'b1, 1'b1, 1'b0, 5'd3}) begin
      miscompares++;
      $display("FAIL b2b_first_read: got %b expected %b", {bus.lookup_ready, bus.pht_en, bus.pht_we, bus.pht_addr}, {1'b1, 1'b1, 1'b0, 5'd3});
    end
    tick();
    bus.lookup_pc = 32'h70;
    settle();
    vectors++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index, bus.pht_addr} !== {1'b1, 1'b0, 5'd3, 5'd4}) begin
      miscompares++;
      $display("FAIL b2b_pred_nt: got %b expected %b", {bus.pred_valid, bus.pred_taken, bus.pred_index, bus.pht_addr}, {1'b1, 1'b0, 5'd3, 5'd4});
    end
    tick();
    bus.lookup_valid = 1'b0;
    settle();
    vectors++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index} !== {1'b1, 1'b1, 5'd4}) begin
      miscompares++;
      $display("FAIL b2b_pred_t: got %b expected %b", {bus.pred_valid, bus.pred_taken, bus.pred_index}, {1'b1, 1'b1, 5'd4});
    end
  endtask

  task automatic test_queue_full();
    logic [4:0] idx_tab [4];
    logic [3:0] tk;
    logic [1:0] wr_tab [4];
    idx_tab = '{5'd8, 5'd9, 5'd10, 5'd11};
    wr_tab  = '{2'b11, 2'b01, 2'b11, 2'b11};
    tk = 4'b1101;
    bus.lookup_pc = 32'h0;
    bus.lookup_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.upd_valid = 1'b1;
      bus.upd_index = idx_tab[i];
      bus.upd_taken = tk[i];
      #1;
      vectors++;
      if ({bus.lookup_ready, bus.upd_ready} !== 2'b11) begin
        miscompares++;
        $display("FAIL qfull_fill%0d: got %b expected 11", i, {bus.lookup_ready, bus.upd_ready});
      end
      tick();
    end
    bus.upd_valid = 1'b0;
    settle();
    vectors++;
    if ({bus.lookup_ready, bus.upd_ready, bus.pht_en, bus.pht_we, bus.pht_addr} !== {4'b0010, 5'd8}) begin
      miscompares++;
      $display("FAIL qfull_rd: got %b expected %b", {bus.lookup_ready, bus.upd_ready, bus.pht_en, bus.pht_we, bus.pht_addr}, {4'b0010, 5'd8});
    end
    tick();
    settle();
    vectors++;
    if ({bus.lookup_ready, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== {2'b01, 5'd8, 2'b11}) begin
      miscompares++;
      $display("FAIL qfull_wr: got %b expected %b", {bus.lookup_ready, bus.pht_we, bus.pht_addr, bus.pht_wdata}, {2'b01, 5'd8, 2'b11});
    end
    tick();
    settle();
    vectors++;
    if ({bus.lookup_ready, bus.upd_ready, bus.pht_en, bus.pht_we, bus.pht_addr} !== {4'b1110, 5'h0B}) begin
      miscompares++;
      $display("FAIL qfull_resume: got %b expected %b", {bus.lookup_ready, bus.upd_ready, bus.pht_en, bus.pht_we, bus.pht_addr}, {4'b1110, 5'h0B});
    end
    tick();
    bus.lookup_valid = 1'b0;
    settle();
    vectors++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index} !== {1'b1, 1'b1, 5'h0B}) begin
      miscompares++;
      $display("FAIL qfull_ghr: got %b expected %b", {bus.pred_valid, bus.pred_taken, bus.pred_index}, {1'b1, 1'b1, 5'h0B});
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if ({bus.pht_en, bus.pht_we, bus.pht_addr} !== {2'b10, idx_tab[i]}) begin
        miscompares++;
        $display("FAIL drain_rd%0d: got %b expected %b", i, {bus.pht_en, bus.pht_we, bus.pht_addr}, {2'b10, idx_tab[i]});
      end
      tick();
      settle();
      vectors++;
      if ({bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== {2'b11, idx_tab[i], wr_tab[i]}) begin
        miscompares++;
        $display("FAIL drain_wr%0d: got %b expected %b", i, {bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata}, {2'b11, idx_tab[i], wr_tab[i]});
      end
      tick();
      settle();
    end
    vectors++;
    if (bus.pht_en !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_idle: got pht_en=%b expected 0", bus.pht_en);
    end
  endtask

  task automatic test_clear_wr();
    int cnt;
    int en_seen;
    bus.upd_valid = 1'b1;
    bus.upd_index = 5'd12;
    bus.upd_taken = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
    settle();
    vectors++;
    if ({bus.pht_en, bus.pht_we, bus.pht_addr} !== {2'b10, 5'd12}) begin
      miscompares++;
      $display("FAIL clr_rd: got %b expected %b", {bus.pht_en, bus.pht_we, bus.pht_addr}, {2'b10, 5'd12});
    end
    tick();
    bus.clear = 1'b1;
    bus.upd_valid = 1'b1;
    bus.upd_index = 5'd13;
    bus.upd_taken = 1'b1;
    #1;
    vectors++;
    if (bus.upd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_upd_ready: got %b expected 1", bus.upd_ready);
    end
    tick();
    bus.clear = 1'b0;
    bus.upd_valid = 1'b0;
    settle();
    vectors++;
    if ({bus.busy, bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata} !== {3'b111, 5'd0, 2'b10}) begin
      miscompares++;
      $display("FAIL clr_restart: got %b expected %b", {bus.busy, bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata}, {3'b111, 5'd0, 2'b10});
    end
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      vectors++;
      if (bus.upd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL clr_sweep_upd_ready%0d: got %b expected 0", cnt, bus.upd_ready);
      end
      cnt++;
      tick();
      settle();
    end
    vectors++;
    if (cnt != 32) begin
      miscompares++;
      $display("FAIL clr_sweep_len: got %0d expected 32", cnt);
    end
    en_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.pht_en !== 1'b0) en_seen++;
      tick();
      settle();
    end
    vectors++;
    if (en_seen != 0) begin
      miscompares++;
      $display("FAIL clr_flushed_queue: got %0d port cycles expected 0", en_seen);
    end
    bus.lookup_valid = 1'b1;
    bus.lookup_pc = 32'h40;
    tick();
    bus.lookup_valid = 1'b0;
    settle();
    vectors++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_index} !== {1'b1, 1'b1, 5'h10}) begin
      miscompares++;
      $display("FAIL clr_ghr_zero: got %b expected %b", {bus.pred_valid, bus.pred_taken, bus.pred_index}, {1'b1, 1'b1, 5'h10});
    end
  endtask

`ifdef PHT_PERF_EN
  task automatic test_perf();
    logic [14:0] lv;
    int n;
    lv = 15'b011_011_0_1111_1111;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 32) begin
      miscompares++;
      $display("FAIL perf_sweep_len: got %0d expected 32", n);
    end
    bus.lookup_pc = 32'h0;
    for (int c = 0; c < 15; c++) begin
      bus.lookup_valid = lv[c];
      bus.upd_valid = (c < 2);
      bus.upd_index = (c == 0) ? 5'd1 : 5'd2;
      bus.upd_taken = 1'b1;
      tick();
    end
    bus.upd_valid = 1'b0;
    bus.lookup_valid = 1'b0;
    settle();
    vectors++;
    if ({perf_lookup_cnt, perf_update_cnt, perf_stall_cnt} !== {32'd10, 32'd2, 32'd2}) begin
      miscompares++;
      $display("FAIL perf_counts: got %0d/%0d/%0d expected 10/2/2", perf_lookup_cnt, perf_update_cnt, perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init_lookup();
    test_counter_sat();
    test_back_to_back();
    test_queue_full();
    test_clear_wr();
`ifdef PHT_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
